// File: rtl/eq_pkg.sv
// Shared equalizer definitions: band/gain widths, accumulator sizing,
// saturation limits, the mixer FSM state type and the round/saturate helper.
package eq_pkg;

    localparam int NUM_BANDS = 8;
    localparam int DATA_W    = 16;
    localparam int GAIN_W    = 8;
    localparam int GAIN_FRAC = 4;
    localparam int ACC_W     = 28;
    localparam int IDX_W     = $clog2(NUM_BANDS);

    // signed sample times zero-extended (hence signed, non-negative) gain
    localparam int PROD_W    = DATA_W + GAIN_W + 1;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT
    } mixer_state_t;

    // Drops the gain fraction with round-half-up (bias by half an LSB, then an
    // arithmetic shift floors) and clamps the result to the output range.
    function automatic logic signed [DATA_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] bias;
        logic signed [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] scaled;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        bias   = $signed(ACC_W'(1 << (GAIN_FRAC - 1)));
        biased = acc + bias;
        scaled = biased >>> GAIN_FRAC;
        hi     = {{(ACC_W-DATA_W){SAT_MAX[DATA_W-1]}}, SAT_MAX};
        lo     = {{(ACC_W-DATA_W){SAT_MIN[DATA_W-1]}}, SAT_MIN};
        if (scaled > hi) begin
            return SAT_MAX;
        end else if (scaled < lo) begin
            return SAT_MIN;
        end else begin
            return scaled[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mixer_mac.sv
// Mixer datapath: one shared signed multiplier, a wide accumulator and the
// round/saturate stage feeding the output register in the top level.
// Ports:
//   clk, rst (async, active-low), clk_enable  - clocking; state holds when enable low
//   acc_clr     - zero the accumulator (start of a new sample set)
//   acc_en      - add sample*gain into the accumulator
//   sample      - signed band sample selected for this step
//   gain        - unsigned Q4.4 gain for the same band
//   result      - rounded, saturated view of the current accumulator
module mixer_mac
    import eq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_enable,
    input  logic                     acc_clr,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;

    // Both operands are widened to the product width so the multiply is a
    // plain signed PROD_W x PROD_W operation whose exact result fits PROD_W.
    always_comb begin
        sample_ext  = {{(PROD_W-DATA_W){sample[DATA_W-1]}}, sample};
        gain_ext    = {{(PROD_W-GAIN_W){1'b0}}, gain};
        product     = sample_ext * gain_ext;
        product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    end

    // Accumulator: 28 bits leaves headroom for eight full-scale products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clk_enable) begin
            if (acc_clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + product_ext;
            end
        end
    end

    assign result = round_sat(acc);

endmodule

// File: rtl/band_gain_mixer.sv
// Equalizer band mixer: captures one sample and one gain per band, walks the
// bands through the shared multiply-accumulate, then rounds/saturates the sum.
// Ports:
//   clk, rst (async, active-low), clk_enable - global advance; all state holds when low
//   band_in/gain_in  - packed per-band samples (signed) and gains (unsigned Q4.4)
//   band_valid       - strobe: a new sample set is present
//   overrun_clr      - clears the sticky overrun flag
//   mix_out          - registered mixed sample
//   mix_valid        - one enabled cycle pulse when mix_out updates
//   busy             - a sample set is in flight
//   overrun          - sticky: a sample set arrived while busy and was dropped
module band_gain_mixer
    import eq_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clk_enable,
    input  logic [NUM_BANDS*DATA_W-1:0]     band_in,
    input  logic                            band_valid,
    input  logic [NUM_BANDS*GAIN_W-1:0]     gain_in,
    input  logic                            overrun_clr,
    output logic signed [DATA_W-1:0]        mix_out,
    output logic                            mix_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    mixer_state_t            state;
    mixer_state_t            next_state;
    logic [IDX_W-1:0]        idx;
    logic signed [DATA_W-1:0] band_reg [NUM_BANDS];
    logic        [GAIN_W-1:0] gain_reg [NUM_BANDS];

    logic                    capture;
    logic                    acc_clr;
    logic                    acc_en;
    logic                    load_out;
    logic                    overrun_set;
    logic signed [DATA_W-1:0] result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (clk_enable) begin
            state <= next_state;
        end
    end

    // A set arriving while not IDLE is never captured; it only raises overrun.
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        load_out    = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (band_valid) begin
                    capture    = 1'b1;
                    acc_clr    = 1'b1;
                    next_state = MAC;
                end
            end
            MAC: begin
                acc_en      = 1'b1;
                overrun_set = band_valid;
                if (idx == LAST_IDX) begin
                    next_state = SAT;
                end
            end
            SAT: begin
                load_out    = 1'b1;
                overrun_set = band_valid;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture registers, band index and output/flag registers. Gains and
    // samples are frozen at capture so upstream may change them freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                band_reg[k] <= '0;
                gain_reg[k] <= '0;
            end
        end else if (clk_enable) begin
            if (capture) begin
                idx <= '0;
                for (int k = 0; k < NUM_BANDS; k++) begin
                    band_reg[k] <= band_in[k*DATA_W +: DATA_W];
                    gain_reg[k] <= gain_in[k*GAIN_W +: GAIN_W];
                end
            end else if (acc_en) begin
                idx <= idx + 1'b1;
            end

            mix_valid <= load_out;
            if (load_out) begin
                mix_out <= result;
            end

            busy <= (next_state != IDLE);

            // a new overrun event takes priority over a simultaneous clear
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    mixer_mac u_mac (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .sample     (band_reg[idx]),
        .gain       (gain_reg[idx]),
        .result     (result)
    );

endmodule

// File: tb/tb_band_gain_mixer.sv
// Directed self-checking bench for band_gain_mixer. Inputs change and outputs
// are sampled on the falling clock edge; expected values are hand-computed.
module tb_band_gain_mixer;

    logic          clk;
    logic          rst_n;
    logic          clk_enable;
    logic [127:0]  band_in;
    logic          band_valid;
    logic [63:0]   gain_in;
    logic          overrun_clr;
    logic [15:0]   mix_out;
    logic          mix_valid;
    logic          busy;
    logic          overrun;

    int compared   = 0;
    int mismatched = 0;
    int n;
    int busy_cnt;
    int stray;

    band_gain_mixer dut (
        .clk         (clk),
        .rst         (rst_n),
        .clk_enable  (clk_enable),
        .band_in     (band_in),
        .band_valid  (band_valid),
        .gain_in     (gain_in),
        .overrun_clr (overrun_clr),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents a set for one enabled edge; on return we sit one cycle past capture.
    task automatic apply_stimulus(input logic [127:0] bands, input logic [63:0] gains,
                                  output int cycles, output int busy_seen);
        band_in    = bands;
        gain_in    = gains;
        band_valid = 1'b1;
        cyc();
        band_valid = 1'b0;
        cycles     = 1;
        busy_seen  = (busy === 1'b1) ? 1 : 0;
    endtask

    // Runs until mix_valid (bounded); counts cycles since capture and busy cycles.
    task automatic finish_set(inout int cycles, inout int busy_seen);
        while (mix_valid !== 1'b1 && cycles < 60) begin
            cyc();
            cycles++;
            if (busy === 1'b1) busy_seen++;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        clk_enable  = 1'b1;
        band_in     = '0;
        band_valid  = 1'b0;
        gain_in     = '0;
        overrun_clr = 1'b0;

        cyc();
        check_output("reset_mix_out",   $signed(mix_out), 0);
        check_output("reset_mix_valid", mix_valid, 0);
        check_output("reset_busy",      busy, 0);
        check_output("reset_overrun",   overrun, 0);
        rst_n = 1'b1;
        cyc();

        // Unity mix: 8 x 1000 x 1.0 = 8000; inputs change after capture
        $display("[TB] unity mix");
        apply_stimulus({8{16'd1000}}, {8{8'h10}}, n, busy_cnt);
        band_in = {8{16'h7FFF}};
        gain_in = {8{8'hFF}};
        finish_set(n, busy_cnt);
        check_output("unity_valid",   mix_valid, 1);
        check_output("unity_latency", n, 10);
        check_output("unity_busy",    busy_cnt, 9);
        check_output("unity_mix_out", $signed(mix_out), 8000);
        cyc();
        check_output("unity_pulse_end", mix_valid, 0);
        check_output("unity_hold",      $signed(mix_out), 8000);

        // Positive saturation, then a negative set accepted in the mix_valid cycle
        $display("[TB] saturation");
        apply_stimulus({8{16'h7FFF}}, {8{8'hFF}}, n, busy_cnt);
        finish_set(n, busy_cnt);
        check_output("satpos_mix_out", $signed(mix_out), 32767);
        apply_stimulus({8{16'h8000}}, {8{8'hFF}}, n, busy_cnt);
        finish_set(n, busy_cnt);
        check_output("satneg_latency", n, 10);
        check_output("satneg_mix_out", $signed(mix_out), -32768);
        check_output("satneg_overrun", overrun, 0);

        // Rounding: 1*0.5 -> 1, -1*0.5 -> 0, -3*0.5 -> -1
        $display("[TB] rounding");
        apply_stimulus({112'd0, 16'h0001}, {56'd0, 8'h08}, n, busy_cnt);
        finish_set(n, busy_cnt);
        check_output("round_p1", $signed(mix_out), 1);
        apply_stimulus({112'd0, 16'hFFFF}, {56'd0, 8'h08}, n, busy_cnt);
        finish_set(n, busy_cnt);
        check_output("round_m1", $signed(mix_out), 0);
        apply_stimulus({112'd0, 16'hFFFD}, {56'd0, 8'h08}, n, busy_cnt);
        finish_set(n, busy_cnt);
        check_output("round_m3", $signed(mix_out), -1);

        // Overrun: bands 100..800 at gain 1.5 -> 3600*1.5 = 5400
        $display("[TB] overrun");
        apply_stimulus({16'd800, 16'd700, 16'd600, 16'd500,
                        16'd400, 16'd300, 16'd200, 16'd100}, {8{8'h18}}, n, busy_cnt);
        repeat (4) begin
            cyc();
            n++;
        end
        band_in    = {8{16'd7000}};
        gain_in    = {8{8'hFF}};
        band_valid = 1'b1;
        cyc();
        n++;
        band_valid = 1'b0;
        check_output("overrun_set", overrun, 1);
        finish_set(n, busy_cnt);
        check_output("overrun_latency", n, 10);
        check_output("overrun_mix_out", $signed(mix_out), 5400);

        // Clear racing a new overrun, then a 5-cycle stall: -500*3.0*8 = -12000
        $display("[TB] clear race and stall");
        apply_stimulus({8{16'hFE0C}}, {8{8'h30}}, n, busy_cnt);
        overrun_clr = 1'b1;
        band_valid  = 1'b1;
        cyc();
        n++;
        overrun_clr = 1'b0;
        band_valid  = 1'b0;
        check_output("clr_race_overrun", overrun, 1);
        cyc();
        n++;
        clk_enable = 1'b0;
        repeat (5) begin
            cyc();
            n++;
        end
        check_output("stall_busy",  busy, 1);
        check_output("stall_valid", mix_valid, 0);
        clk_enable = 1'b1;
        finish_set(n, busy_cnt);
        check_output("stall_latency", n, 15);
        check_output("stall_mix_out", $signed(mix_out), -12000);
        clk_enable = 1'b0;
        cyc();
        check_output("stall_valid_stretch", mix_valid, 1);
        clk_enable = 1'b1;
        cyc();
        check_output("stall_valid_end", mix_valid, 0);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        check_output("overrun_clear", overrun, 0);

        // Reset mid-MAC at idx=3 with overrun set and a nonzero mix_out
        $display("[TB] reset mid computation");
        apply_stimulus({8{16'd1000}}, {8{8'h10}}, n, busy_cnt);
        band_valid = 1'b1;
        cyc();
        band_valid = 1'b0;
        cyc();
        cyc();
        check_output("pre_reset_overrun", overrun, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_busy",      busy, 0);
        check_output("midrst_mix_valid", mix_valid, 0);
        check_output("midrst_mix_out",   $signed(mix_out), 0);
        check_output("midrst_overrun",   overrun, 0);
        cyc();
        rst_n = 1'b1;
        stray = 0;
        repeat (15) begin
            cyc();
            if (mix_valid !== 1'b0) stray++;
        end
        check_output("post_reset_no_valid", stray, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
